// File: rtl/compress_line_sequencer_if.sv
// compress_line_sequencer_if: line/word/pack/done handshake bundle for compress_line_sequencer
//   line  : i_line_valid / o_line_ready     start a new line
//   word  : i_word_valid / o_word_ready     per-word i_code, i_length; i_flush aborts the line
//   pack  : o_pack_valid strobe with o_pack_code, o_pack_length, o_pack_offset
//   done  : o_done_valid / i_done_ready     o_total_bits, o_compressible, o_err
interface compress_line_sequencer_if #(parameter int TOT_W = 10);
  logic             i_line_valid;
  logic             o_line_ready;
  logic             i_flush;
  logic             i_word_valid;
  logic             o_word_ready;
  logic [2:0]       i_code;
  logic [5:0]       i_length;
  logic             o_pack_valid;
  logic [2:0]       o_pack_code;
  logic [5:0]       o_pack_length;
  logic [TOT_W-1:0] o_pack_offset;
  logic             o_done_valid;
  logic             i_done_ready;
  logic [TOT_W-1:0] o_total_bits;
  logic             o_compressible;
  logic             o_err;
  modport master (
    output i_line_valid, i_flush, i_word_valid, i_code, i_length, i_done_ready,
    input  o_line_ready, o_word_ready, o_pack_valid, o_pack_code, o_pack_length, o_pack_offset,
           o_done_valid, o_total_bits, o_compressible, o_err
  );
  modport slave (
    input  i_line_valid, i_flush, i_word_valid, i_code, i_length, i_done_ready,
    output o_line_ready, o_word_ready, o_pack_valid, o_pack_code, o_pack_length, o_pack_offset,
           o_done_valid, o_total_bits, o_compressible, o_err
  );
endinterface

// File: rtl/compress_line_sequencer.sv
// compress_line_sequencer: walks one cache line word by word, assigns bit offsets and totals the compressed length
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : compress_line_sequencer_if.slave (line, word, pack and done handshakes)
module compress_line_sequencer #(
  parameter int WORDS_PER_LINE = 16,
  parameter int TOT_W          = 10,
  parameter int RAW_BITS       = 512
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  compress_line_sequencer_if.slave   bus
);
  localparam int CW = $clog2(WORDS_PER_LINE);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [TOT_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pack_valid_q;
  logic [2:0]       pack_code_q;
  logic [5:0]       pack_len_q;
  logic [TOT_W-1:0] pack_off_q;
  logic             accept;
  assign accept = (state_q == RUN) & bus.i_word_valid & ~bus.i_flush;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE && bus.i_line_valid) begin
      state_d = RUN;
      acc_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      acc_d   = acc_q + TOT_W'(bus.i_length);
      cnt_d   = cnt_q + 1'b1;
      err_d   = err_q | (bus.i_code[2] & bus.i_code[1]);
      state_d = (cnt_q == CW'(WORDS_PER_LINE - 1)) ? DONE : RUN;
    end else if (state_q == DONE && bus.i_done_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      pack_valid_q <= 1'b0;
      pack_code_q  <= '0;
      pack_len_q   <= '0;
      pack_off_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      pack_valid_q <= accept;
      if (accept) begin
        pack_code_q <= bus.i_code;
        pack_len_q  <= bus.i_length;
        pack_off_q  <= acc_q;
      end
    end
  end
  assign bus.o_line_ready   = state_q == IDLE;
  assign bus.o_word_ready   = state_q == RUN;
  assign bus.o_pack_valid   = pack_valid_q;
  assign bus.o_pack_code    = pack_code_q;
  assign bus.o_pack_length  = pack_len_q;
  assign bus.o_pack_offset  = pack_off_q;
  assign bus.o_done_valid   = state_q == DONE;
  assign bus.o_total_bits   = acc_q;
  // only meaningful while a result is presented, so it reads 0 out of reset
  assign bus.o_compressible = (state_q == DONE) & (acc_q < TOT_W'(RAW_BITS)) & ~err_q;
  assign bus.o_err          = err_q;
endmodule
